// File: rtl/dot_matrix_text_scroller.sv
`default_nettype none
// ============================================================================
// dot_matrix_text_scroller
// Row-multiplexed dot-matrix driver that scrolls a small text buffer leftwards.
// Revision: 1.0
// ============================================================================
module dot_matrix_text_scroller #(
  parameter int NUM_CHARS     = 4,
  parameter int ROWS          = 8,
  parameter int COLS          = 8,
  parameter int ROW_DIV       = 1000,
  parameter int SCROLL_FRAMES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_CHARS)-1:0]  wr_addr,
  input  logic [6:0]                    wr_char,
  input  logic                          scroll_en,
  output logic [7+$clog2(ROWS)-1:0]     rom_addr,
  input  logic [COLS-1:0]               rom_data,
  output logic [ROWS-1:0]               row,
  output logic [COLS-1:0]               col,
  output logic                          frame_done
);

  localparam int AW = $clog2(NUM_CHARS);
  localparam int RW = $clog2(ROWS);
  localparam int OW = $clog2(COLS);
  localparam int DW = $clog2(ROW_DIV);
  localparam int FW = $clog2(SCROLL_FRAMES + 1);
  localparam int IW = $clog2(2 * COLS);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH_A = 2'd1;
  localparam logic [1:0] S_FETCH_B = 2'd2;
  localparam logic [1:0] S_COMMIT  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [6:0]      buf_q [NUM_CHARS];
  logic [DW-1:0]   div_q, div_d;
  logic [RW-1:0]   row_idx_q, row_idx_d;
  logic [AW-1:0]   char_idx_q, char_idx_d;
  logic [OW-1:0]   offset_q, offset_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [COLS-1:0] a_q, a_d;
  logic [ROWS-1:0] row_q, row_d;
  logic [COLS-1:0] col_q, col_d;
  logic            frame_q, frame_d;

  logic            w_tick;
  logic            w_last_row;
  logic            w_cap_a;
  logic            w_commit;
  logic [AW-1:0]   w_char_nxt;
  logic [AW-1:0]   w_sel_char;
  logic [2*COLS-1:0] w_cat;
  logic [COLS-1:0] w_win;

  assign w_tick     = (div_q == DW'(ROW_DIV - 1));
  assign w_last_row = (row_idx_q == RW'(ROWS - 1));
  assign w_char_nxt = (char_idx_q == AW'(NUM_CHARS - 1)) ? '0 : char_idx_q + 1'b1;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (w_tick) state_d = S_FETCH_A;
      S_FETCH_A: state_d = S_FETCH_B;
      S_FETCH_B: state_d = S_COMMIT;
      S_COMMIT:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_sel_char = char_idx_q;
    w_cap_a    = 1'b0;
    w_commit   = 1'b0;
    case (state_q)
      S_FETCH_B: begin
        w_sel_char = w_char_nxt;
        w_cap_a    = 1'b1;
      end
      S_COMMIT:  w_commit = 1'b1;
      default:   ;
    endcase
    rom_addr = {buf_q[w_sel_char], row_idx_q};
  end

  // Visible window is the upper half of {A,B} shifted left by offset.
  assign w_cat = {a_q, rom_data};
  always_comb begin
    w_win = '0;
    for (int i = 0; i < COLS; i++) begin
      w_win[i] = w_cat[IW'(COLS + i) - IW'(offset_q)];
    end
  end

  always_comb begin
    div_d      = w_tick ? '0 : div_q + 1'b1;
    a_d        = w_cap_a ? rom_data : a_q;
    row_idx_d  = row_idx_q;
    row_d      = row_q;
    col_d      = col_q;
    frame_d    = 1'b0;
    offset_d   = offset_q;
    char_idx_d = char_idx_q;
    fcnt_d     = fcnt_q;
    if (w_commit) begin
      row_idx_d = w_last_row ? '0 : row_idx_q + 1'b1;
      row_d     = ROWS'(1) << row_idx_q;
      col_d     = w_win;
      frame_d   = w_last_row;
      // Scroll state only moves at the frame boundary so a frame never tears.
      if (w_last_row && scroll_en) begin
        if (fcnt_q == FW'(SCROLL_FRAMES - 1)) begin
          fcnt_d = '0;
          if (offset_q == OW'(COLS - 1)) begin
            offset_d   = '0;
            char_idx_d = w_char_nxt;
          end else begin
            offset_d = offset_q + 1'b1;
          end
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      row_idx_q  <= '0;
      char_idx_q <= '0;
      offset_q   <= '0;
      fcnt_q     <= '0;
      a_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      frame_q    <= 1'b0;
    end else begin
      div_q      <= div_d;
      row_idx_q  <= row_idx_d;
      char_idx_q <= char_idx_d;
      offset_q   <= offset_d;
      fcnt_q     <= fcnt_d;
      a_q        <= a_d;
      row_q      <= row_d;
      col_q      <= col_d;
      frame_q    <= frame_d;
    end
  end

  // A write racing a fetch of the same slot lands after the ROM has sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHARS; i++) buf_q[i] <= 7'h20;
    end else if (wr_en && ({1'b0, wr_addr} < (AW+1)'(NUM_CHARS))) begin
      buf_q[wr_addr] <= wr_char;
    end
  end

  assign row        = row_q;
  assign col        = col_q;
  assign frame_done = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_dot_matrix_text_scroller.sv
`default_nettype none
// ============================================================================
// tb_dot_matrix_text_scroller
// Randomised bench for the text scroller against a pixel-strip display model.
// Revision: 1.0
// ============================================================================
module tb_dot_matrix_text_scroller;

  localparam int NC   = 4;
  localparam int NR   = 8;
  localparam int NCOL = 8;
  localparam int RD   = 4;
  localparam int SF   = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [6:0] wr_char = '0;
  logic       scroll_en = 1'b0;
  logic [9:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic [7:0] row;
  logic [7:0] col;
  logic       frame_done;

  dot_matrix_text_scroller #(
    .NUM_CHARS(NC), .ROWS(NR), .COLS(NCOL), .ROW_DIV(RD), .SCROLL_FRAMES(SF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .scroll_en(scroll_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .row(row), .col(col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input logic [6:0] a, input int r);
    logic [15:0] h;
    h = 16'(a) * 16'd157 + 16'(r) * 16'd61 + (16'(a) ^ 16'(r * 37));
    return h[11:4] ^ {a, 1'b1};
  endfunction

  always @(posedge clk) rom_data <= glyph(rom_addr[9:3], int'(rom_addr[2:0]));

  // Screen pixel j (0 = leftmost) is strip pixel off+j of the two glyphs side by side.
  function automatic logic [7:0] window(input logic [7:0] a, input logic [7:0] b, input int off);
    logic [7:0] w;
    int k;
    for (int j = 0; j < NCOL; j++) begin
      k = j + off;
      w[NCOL-1-j] = (k < NCOL) ? a[NCOL-1-k] : b[2*NCOL-1-k];
    end
    return w;
  endfunction

  int         ncyc, steps, fcnt, n_checks, n_pass;
  int         cur_k, cur_r, cur_ci;
  logic [6:0] mtext [NC];
  logic [7:0] snap_a, snap_b, exp_row, exp_col;
  logic       exp_fd;

  task automatic model_reset();
    for (int i = 0; i < NC; i++) mtext[i] = 7'h20;
    steps = 0; fcnt = 0; ncyc = 0; cur_k = -1; cur_r = 0; cur_ci = 0;
    exp_row = '0; exp_col = '0; exp_fd = 1'b0;
  endtask

  task automatic apply_reset();
    wr_en = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock: advance the DUT and the display model together.
  task automatic step();
    int off;
    @(posedge clk);
    ncyc++;
    exp_fd = 1'b0;
    cur_k  = -1;
    if (ncyc >= RD) begin
      cur_k  = ncyc % RD;
      cur_r  = (ncyc / RD - 1) % NR;
      cur_ci = (steps / NCOL) % NC;
      off    = steps % NCOL;
      if (cur_k == 1) snap_a = glyph(mtext[cur_ci], cur_r);
      else if (cur_k == 2) snap_b = glyph(mtext[(cur_ci + 1) % NC], cur_r);
      else if (cur_k == 3) begin
        exp_row = 8'(1 << cur_r);
        exp_col = window(snap_a, snap_b, off);
        if (cur_r == NR - 1) begin
          exp_fd = 1'b1;
          if (scroll_en) begin
            fcnt++;
            if (fcnt == SF) begin fcnt = 0; steps++; end
          end
        end
      end
    end
    if (wr_en && int'(wr_addr) < NC) mtext[wr_addr] = wr_char;
    #1;
  endtask

  task automatic write_char(input logic [1:0] a, input logic [6:0] c);
    wr_en = 1'b1; wr_addr = a; wr_char = c;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (row !== 8'h00 || col !== 8'h00 || frame_done !== 1'b0)
      $display("FAIL reset_outputs: got row=%h col=%h fd=%b want 00/00/0", row, col, frame_done);
    else n_pass++;
    apply_reset();
    for (int i = 0; i < RD + 2; i++) begin
      step();
      n_checks++;
      if (row !== 8'h00 || col !== 8'h00 || frame_done !== 1'b0)
        $display("FAIL reset_quiet cyc%0d: got row=%h col=%h fd=%b want 00/00/0", ncyc, row, col, frame_done);
      else n_pass++;
    end
    step();
    n_checks++;
    if (row !== 8'h01 || col !== glyph(7'h20, 0) || frame_done !== 1'b0)
      $display("FAIL first_commit: got row=%h col=%h fd=%b want 01/%h/0", row, col, frame_done, glyph(7'h20, 0));
    else n_pass++;
  endtask

  task automatic test_static();
    int pulses;
    apply_reset();
    scroll_en = 1'b0;
    write_char(2'd0, 7'h41);
    write_char(2'd1, 7'h42);
    write_char(2'd2, 7'($urandom_range(33, 126)));
    write_char(2'd3, 7'($urandom_range(33, 126)));
    pulses = 0;
    for (int i = 0; i < 2 * NR * RD; i++) begin
      step();
      if (frame_done === 1'b1) pulses++;
      n_checks++;
      if (row !== exp_row || col !== exp_col || frame_done !== exp_fd)
        $display("FAIL static_display cyc%0d: got %h/%h/%b want %h/%h/%b", ncyc, row, col, frame_done, exp_row, exp_col, exp_fd);
      else n_pass++;
      if (cur_k == 0) begin
        n_checks++;
        if (rom_addr !== {7'h41, 3'(cur_r)})
          $display("FAIL rom_addr_a cyc%0d: got %h want %h", ncyc, rom_addr, {7'h41, 3'(cur_r)});
        else n_pass++;
      end
      if (cur_k == 1) begin
        n_checks++;
        if (rom_addr !== {7'h42, 3'(cur_r)})
          $display("FAIL rom_addr_b cyc%0d: got %h want %h", ncyc, rom_addr, {7'h42, 3'(cur_r)});
        else n_pass++;
      end
      if (cur_k == 3) begin
        n_checks++;
        if (col !== glyph(7'h41, cur_r))
          $display("FAIL static_glyph_A row%0d: got %h want %h", cur_r, col, glyph(7'h41, cur_r));
        else n_pass++;
      end
    end
    n_checks++;
    if (pulses !== 2) $display("FAIL frame_rate: got %0d pulses want 2", pulses);
    else n_pass++;
  endtask

  task automatic test_scroll();
    int frames;
    logic [7:0] ga, gb;
    apply_reset();
    write_char(2'd0, 7'h41);
    write_char(2'd1, 7'h42);
    write_char(2'd2, 7'h43);
    write_char(2'd3, 7'h44);
    scroll_en = 1'b1;
    frames = 0;
    for (int i = 0; i < 9 * NR * RD + RD; i++) begin
      step();
      n_checks++;
      if (row !== exp_row || col !== exp_col || frame_done !== exp_fd)
        $display("FAIL scroll_display cyc%0d: got %h/%h/%b want %h/%h/%b", ncyc, row, col, frame_done, exp_row, exp_col, exp_fd);
      else n_pass++;
      if (cur_k == 3 && (frames == 3 || frames == 8)) begin
        ga = glyph(7'h41, cur_r);
        gb = glyph(7'h42, cur_r);
        n_checks++;
        if (frames == 3 && col !== (8'(ga << 3) | (gb >> 5)))
          $display("FAIL scroll_off3 row%0d: got %h want %h", cur_r, col, 8'(ga << 3) | (gb >> 5));
        else if (frames == 8 && col !== gb)
          $display("FAIL scroll_char1 row%0d: got %h want %h", cur_r, col, gb);
        else n_pass++;
      end
      if (frame_done === 1'b1) frames++;
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < NC; i++) write_char(2'(i), 7'(8'h50 + i * 3));
    scroll_en = 1'b1;
    for (int i = 0; i < 33 * NR * RD; i++) begin
      step();
      n_checks++;
      if (row !== exp_row || col !== exp_col || frame_done !== exp_fd)
        $display("FAIL wrap_display cyc%0d step%0d: got %h/%h/%b want %h/%h/%b", ncyc, steps, row, col, frame_done, exp_row, exp_col, exp_fd);
      else n_pass++;
    end
  endtask

  task automatic test_write_collision();
    int r, r2, guard;
    logic [7:0] want;
    apply_reset();
    write_char(2'd0, 7'h41);
    write_char(2'd1, 7'h42);
    scroll_en = 1'b1;
    guard = 0;
    while (steps < 7 && guard < 10 * NR * RD) begin step(); guard++; end
    scroll_en = 1'b0;
    guard = 0;
    while (cur_k != 1 && guard < 2 * RD) begin step(); guard++; end
    n_checks++;
    if (cur_k != 1 || steps != 7) $display("FAIL collision_setup: got phase %0d step %0d want 1/7", cur_k, steps);
    else n_pass++;
    r = cur_r;
    wr_en = 1'b1; wr_addr = 2'd1; wr_char = 7'h5A;
    step();
    wr_en = 1'b0;
    step();
    want = window(glyph(7'h41, r), glyph(7'h42, r), 7);
    n_checks++;
    if (col !== want || col !== exp_col)
      $display("FAIL collision_old row%0d: got %h want %h", r, col, want);
    else n_pass++;
    for (int i = 0; i < RD; i++) step();
    r2 = (r + 1) % NR;
    want = window(glyph(7'h41, r2), glyph(7'h5A, r2), 7);
    n_checks++;
    if (col !== want || row !== 8'(1 << r2))
      $display("FAIL collision_new row%0d: got %h/%h want %h/%h", r2, row, col, 8'(1 << r2), want);
    else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    scroll_en = 1'b1;
    for (int i = 0; i < 800; i++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_char = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 63) == 0) scroll_en = ~scroll_en;
      step();
      n_checks++;
      if (row !== exp_row || col !== exp_col || frame_done !== exp_fd)
        $display("FAIL random_display cyc%0d: got %h/%h/%b want %h/%h/%b", ncyc, row, col, frame_done, exp_row, exp_col, exp_fd);
      else n_pass++;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset_midfetch();
    int guard;
    guard = 0;
    while (cur_k != 1 && guard < 2 * RD) begin step(); guard++; end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (row !== 8'h00 || col !== 8'h00 || frame_done !== 1'b0)
      $display("FAIL midfetch_reset: got row=%h col=%h fd=%b want 00/00/0", row, col, frame_done);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < RD + 2; i++) begin
      step();
      n_checks++;
      if (row !== 8'h00 || col !== 8'h00)
        $display("FAIL midfetch_early_commit cyc%0d: got row=%h col=%h want 00/00", ncyc, row, col);
      else n_pass++;
    end
    step();
    n_checks++;
    if (row !== 8'h01 || col !== exp_col)
      $display("FAIL midfetch_first_commit: got row=%h col=%h want 01/%h", row, col, exp_col);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_reset();
    test_reset();
    test_static();
    test_scroll();
    test_wrap();
    test_write_collision();
    test_random();
    test_reset_midfetch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
